// File: rtl/ofdmbbp_rx_capture_pkg.sv
// Shared definitions for the OFDM BBP RX capture block: command word layout,
// mode codes, FSM state encodings and the buffered sample format.
package ofdmbbp_rx_capture_pkg;

   localparam int unsigned CMD_LEN_LSB   = 0;
   localparam int unsigned CMD_LEN_W     = 8;
   localparam int unsigned CMD_MODE_LSB  = 8;
   localparam int unsigned CMD_MODE_W    = 2;
   localparam int unsigned CMD_PAUSE_LSB = 10;
   localparam int unsigned CMD_PAUSE_W   = 22;
   localparam int unsigned SAMPLE_W      = 16;
   localparam int unsigned MAG_W         = 17;

   localparam logic [1:0] MODE_CH0  = 2'd0;
   localparam logic [1:0] MODE_CH1  = 2'd1;
   localparam logic [1:0] MODE_TRIG = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLDOFF = 2'd1;
   localparam logic [1:0] ST_TRIG    = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   typedef struct packed {
      logic                last;
      logic [SAMPLE_W-1:0] q;
      logic [SAMPLE_W-1:0] i;
   } sample_t;

   // |I|+|Q| widened so that |-32768| = 32768 and the sum cannot wrap
   function automatic logic [MAG_W-1:0] iq_mag(input logic [SAMPLE_W-1:0] i,
                                               input logic [SAMPLE_W-1:0] q);
      logic [MAG_W-1:0] a_i;
      logic [MAG_W-1:0] a_q;
      a_i = i[SAMPLE_W-1] ? (MAG_W'(0) - {i[SAMPLE_W-1], i}) : {1'b0, i};
      a_q = q[SAMPLE_W-1] ? (MAG_W'(0) - {q[SAMPLE_W-1], q}) : {1'b0, q};
      return a_i + a_q;
   endfunction

endpackage

// File: rtl/ofdmbbp_sfifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is
// accepted only when a read retires an entry in the same cycle.
module ofdmbbp_sfifo #(
   parameter int unsigned WIDTH      = 33,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_empty_nxt_c
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_empty;
   logic                  r_full;
   logic                  w_wr;
   logic                  w_rd;
   logic [CNT_W-1:0]      w_count_nxt;

   assign w_rd        = i_rd_en && !r_empty;
   assign w_wr        = i_wr_en && (!r_full || w_rd);
   assign w_count_nxt = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);

   assign o_rd_data     = r_empty ? '0 : r_mem[r_rd_ptr];
   assign o_empty       = r_empty;
   assign o_full        = r_full;
   assign o_empty_nxt_c = (w_count_nxt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      end
   end

   // Storage carries no reset; the read port is masked while empty
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule

// File: rtl/ofdmbbp_rx_capture.sv
// RX capture: command-driven ADC I/Q capture (holdoff, magnitude trigger,
// fixed-length capture) feeding a FWFT sample buffer with overflow accounting.
module ofdmbbp_rx_capture
   import ofdmbbp_rx_capture_pkg::*;
#(
   parameter int unsigned FIFO_ADDR_WIDTH = 5,
   parameter int unsigned DROP_CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      adc_valid_i0,
   input  logic [15:0]               adc_data_i0,
   input  logic [15:0]               adc_data_q0,
   input  logic                      adc_valid_i1,
   input  logic [15:0]               adc_data_i1,
   input  logic [15:0]               adc_data_q1,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [31:0]               cmd_bits,
   input  logic [16:0]               trig_level,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [31:0]               dout_bits,
   output logic                      dout_last,
   output logic                      busy,
   output logic                      ovf,
   input  logic                      ovf_clr,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);

   logic [1:0]                r_state;
   logic [CMD_MODE_W-1:0]     r_mode;
   logic [CMD_LEN_W-1:0]      r_len;
   logic [CMD_PAUSE_W-1:0]    r_pause;
   logic [CMD_PAUSE_W-1:0]    r_cnt;
   logic                      r_cmd_ready;
   logic                      r_s_valid;
   sample_t                   r_s_word;
   logic                      r_busy;
   logic                      r_ovf;
   logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

   logic [1:0]                w_state_nxt;
   logic [CMD_PAUSE_W-1:0]    w_cnt_nxt;
   logic                      w_push;
   logic                      w_last;
   logic                      w_cmd_accept;
   logic [CMD_MODE_W-1:0]     w_cmd_mode;
   logic [CMD_LEN_W-1:0]      w_cmd_len;
   logic [CMD_PAUSE_W-1:0]    w_cmd_pause;
   logic                      w_sel_valid;
   logic [SAMPLE_W-1:0]       w_sel_i;
   logic [SAMPLE_W-1:0]       w_sel_q;
   logic [MAG_W-1:0]          w_mag;
   sample_t                   w_rd_word;
   logic                      w_fifo_empty;
   logic                      w_fifo_full;
   logic                      w_fifo_empty_nxt;
   logic                      w_pop;
   logic                      w_drop;

   assign w_cmd_accept = cmd_valid && r_cmd_ready;
   assign w_cmd_mode   = cmd_bits[CMD_MODE_LSB +: CMD_MODE_W];
   assign w_cmd_len    = cmd_bits[CMD_LEN_LSB +: CMD_LEN_W];
   assign w_cmd_pause  = cmd_bits[CMD_PAUSE_LSB +: CMD_PAUSE_W];

   // Channel 1 only in mode 1; triggered capture watches channel 0
   always_comb begin
      w_sel_valid = adc_valid_i0;
      w_sel_i     = adc_data_i0;
      w_sel_q     = adc_data_q0;
      case (r_mode)
         MODE_CH1: begin
            w_sel_valid = adc_valid_i1;
            w_sel_i     = adc_data_i1;
            w_sel_q     = adc_data_q1;
         end
         MODE_CH0, MODE_TRIG: ;
         default: ;
      endcase
   end

   assign w_mag = iq_mag(w_sel_i, w_sel_q);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_push      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_accept) begin
               w_cnt_nxt = '0;
               if (w_cmd_mode == MODE_RSVD)       w_state_nxt = ST_IDLE;
               else if (w_cmd_pause != '0)        w_state_nxt = ST_HOLDOFF;
               else if (w_cmd_mode == MODE_TRIG)  w_state_nxt = ST_TRIG;
               else                               w_state_nxt = ST_CAPTURE;
            end
         end
         ST_HOLDOFF: begin
            if (w_sel_valid) begin
               if (r_cnt == r_pause - CMD_PAUSE_W'(1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = (r_mode == MODE_TRIG) ? ST_TRIG : ST_CAPTURE;
               end else begin
                  w_cnt_nxt = r_cnt + CMD_PAUSE_W'(1);
               end
            end
         end
         ST_TRIG: begin
            // The triggering sample is itself sample #1 of the capture
            if (w_sel_valid && (w_mag >= trig_level)) begin
               w_push = 1'b1;
               if (r_len == '0) begin
                  w_last      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt   = CMD_PAUSE_W'(1);
                  w_state_nxt = ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE: begin
            if (w_sel_valid) begin
               w_push = 1'b1;
               if (r_cnt == CMD_PAUSE_W'(r_len)) begin
                  w_last      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CMD_PAUSE_W'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mode      <= MODE_CH0;
         r_len       <= '0;
         r_pause     <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_s_valid   <= 1'b0;
         r_s_word    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cmd_ready <= (w_state_nxt == ST_IDLE);
         r_s_valid   <= w_push;
         if (w_cmd_accept) begin
            r_mode  <= w_cmd_mode;
            r_len   <= w_cmd_len;
            r_pause <= w_cmd_pause;
         end
         if (w_push) r_s_word <= '{last: w_last, q: w_sel_q, i: w_sel_i};
      end
   end

   ofdmbbp_sfifo #(
      .WIDTH      ($bits(sample_t)),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_buf (
      .clk           (clk),
      .rst           (rst),
      .i_wr_en       (r_s_valid),
      .i_wr_data     (r_s_word),
      .i_rd_en       (dout_ready),
      .o_rd_data     (w_rd_word),
      .o_empty       (w_fifo_empty),
      .o_full        (w_fifo_full),
      .o_empty_nxt_c (w_fifo_empty_nxt)
   );

   assign w_pop  = !w_fifo_empty && dout_ready;
   assign w_drop = r_s_valid && w_fifo_full && !w_pop;

   // A drop in the same cycle as ovf_clr restarts the count at one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= 1'b0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE) || w_push || !w_fifo_empty_nxt;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr)                r_drop_cnt <= DROP_CNT_WIDTH'(1);
            else if (r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
         end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
         end
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign dout_valid = !w_fifo_empty;
   assign dout_bits  = {w_rd_word.q, w_rd_word.i};
   assign dout_last  = w_rd_word.last;
   assign busy       = r_busy;
   assign ovf        = r_ovf;
   assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_ofdmbbp_rx_capture.sv
// Directed bench for ofdmbbp_rx_capture: a cycle table for basic captures plus
// hand sequences for overflow, reset mid-capture and reserved-mode commands.
module tb_ofdmbbp_rx_capture;

   logic        clk;
   logic        rst;
   logic        adc_valid_i0;
   logic [15:0] adc_data_i0;
   logic [15:0] adc_data_q0;
   logic        adc_valid_i1;
   logic [15:0] adc_data_i1;
   logic [15:0] adc_data_q1;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_bits;
   logic [16:0] trig_level;
   logic        dout_valid;
   logic        dout_ready;
   logic [31:0] dout_bits;
   logic        dout_last;
   logic        busy;
   logic        ovf;
   logic        ovf_clr;
   logic [15:0] drop_count;

   int n_pass;
   int n_total;

   ofdmbbp_rx_capture #(
      .FIFO_ADDR_WIDTH (5),
      .DROP_CNT_WIDTH  (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .adc_valid_i0 (adc_valid_i0),
      .adc_data_i0  (adc_data_i0),
      .adc_data_q0  (adc_data_q0),
      .adc_valid_i1 (adc_valid_i1),
      .adc_data_i1  (adc_data_i1),
      .adc_data_q1  (adc_data_q1),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_bits     (cmd_bits),
      .trig_level   (trig_level),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout_bits    (dout_bits),
      .dout_last    (dout_last),
      .busy         (busy),
      .ovf          (ovf),
      .ovf_clr      (ovf_clr),
      .drop_count   (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cmd_v;
      logic [31:0] cmd;
      logic [16:0] trig;
      logic        v0;
      logic [15:0] i0;
      logic [15:0] q0;
      logic        v1;
      logic [15:0] i1;
      logic [15:0] q1;
      logic        e_valid;
      logic [31:0] e_bits;
      logic        e_last;
      logic        e_rdy;
   } vec_t;

   localparam int NROWS = 29;
   vec_t tbl [NROWS];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic set_cmd(input int k, input logic [31:0] b);
      tbl[k].cmd_v = 1'b1;
      tbl[k].cmd   = b;
   endtask

   task automatic set_s0(input int k, input logic [15:0] i, input logic [15:0] q);
      tbl[k].v0 = 1'b1;
      tbl[k].i0 = i;
      tbl[k].q0 = q;
   endtask

   task automatic set_s1(input int k, input logic [15:0] i, input logic [15:0] q);
      tbl[k].v1 = 1'b1;
      tbl[k].i1 = i;
      tbl[k].q1 = q;
   endtask

   task automatic set_exp(input int k, input logic [31:0] b, input logic l);
      tbl[k].e_valid = 1'b1;
      tbl[k].e_bits  = b;
      tbl[k].e_last  = l;
   endtask

   // Advance to just after the next rising edge and clear one-shot inputs
   task automatic next_row();
      @(posedge clk);
      #1;
      cmd_valid    = 1'b0;
      adc_valid_i0 = 1'b0;
      adc_valid_i1 = 1'b0;
      ovf_clr      = 1'b0;
   endtask

   // Present a command on the first row where cmd_ready is seen high
   task automatic issue_cmd(input logic [31:0] b);
      logic ok;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         next_row();
         if (cmd_ready) begin
            cmd_valid = 1'b1;
            cmd_bits  = b;
            ok        = 1'b1;
         end
      end
      chk("cmd_ready_within_bound", 64'(ok), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      n_pass = 0;
      n_total = 0;

      for (int k = 0; k < NROWS; k++) begin
         tbl[k] = '{cmd_v: 1'b0, cmd: 32'h0, trig: 17'd0, v0: 1'b0, i0: 16'h0, q0: 16'h0,
                    v1: 1'b0, i1: 16'h0, q1: 16'h0, e_valid: 1'b0, e_bits: 32'h0,
                    e_last: 1'b0, e_rdy: 1'b0};
      end
      // mode 0, length 3: strobes every second cycle, word 2 cycles after strobe
      set_cmd(0, 32'h0000_0003);
      set_s0(1, 16'h0001, 16'hFFFF);
      set_s0(3, 16'h0002, 16'hFFFE);
      set_s0(5, 16'h0003, 16'hFFFD);
      set_s0(7, 16'h0004, 16'hFFFC);
      set_exp(3, 32'hFFFF_0001, 1'b0);
      set_exp(5, 32'hFFFE_0002, 1'b0);
      set_exp(7, 32'hFFFD_0003, 1'b0);
      set_exp(9, 32'hFFFC_0004, 1'b1);
      // mode 1, pause 2, length 0: ch0 ignored, third ch1 sample captured
      set_cmd(11, 32'h0000_0900);
      set_s0(12, 16'h0005, 16'h0000);
      set_s1(13, 16'd10, 16'h0000);
      set_s0(14, 16'h0006, 16'h0000);
      set_s1(15, 16'd20, 16'h0000);
      set_s0(16, 16'h0007, 16'h0000);
      set_s1(17, 16'd30, 16'h0000);
      set_exp(19, 32'h0000_001E, 1'b1);
      // mode 2, trigger 1000, length 1: magnitudes 100, 999, 1000, 5
      set_cmd(21, 32'h0000_0201);
      for (int k = 21; k < NROWS; k++) tbl[k].trig = 17'd1000;
      set_s0(22, 16'd50,   16'hFFCE);
      set_s0(23, 16'hFE0C, 16'h01F3);
      set_s0(24, 16'h0258, 16'hFE70);
      set_s0(25, 16'h0002, 16'hFFFD);
      set_exp(26, 32'hFE70_0258, 1'b0);
      set_exp(27, 32'hFFFD_0002, 1'b1);
      foreach (tbl[k]) begin
         if (k == 0 || (k >= 8 && k <= 11) || (k >= 18 && k <= 21) || k >= 26)
            tbl[k].e_rdy = 1'b1;
      end

      rst          = 1'b1;
      adc_valid_i0 = 1'b0;
      adc_data_i0  = '0;
      adc_data_q0  = '0;
      adc_valid_i1 = 1'b0;
      adc_data_i1  = '0;
      adc_data_q1  = '0;
      cmd_valid    = 1'b0;
      cmd_bits     = '0;
      trig_level   = '0;
      dout_ready   = 1'b1;
      ovf_clr      = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_cmd_ready",  64'(cmd_ready),  64'd1);
      chk("reset_dout_valid", 64'(dout_valid), 64'd0);
      chk("reset_dout_bits",  64'(dout_bits),  64'd0);
      chk("reset_dout_last",  64'(dout_last),  64'd0);
      chk("reset_busy",       64'(busy),       64'd0);
      chk("reset_ovf",        64'(ovf),        64'd0);
      chk("reset_drop_count", 64'(drop_count), 64'd0);

      for (int k = 0; k < NROWS; k++) begin
         next_row();
         cmd_valid    = tbl[k].cmd_v;
         cmd_bits     = tbl[k].cmd;
         trig_level   = tbl[k].trig;
         adc_valid_i0 = tbl[k].v0;
         adc_data_i0  = tbl[k].i0;
         adc_data_q0  = tbl[k].q0;
         adc_valid_i1 = tbl[k].v1;
         adc_data_i1  = tbl[k].i1;
         adc_data_q1  = tbl[k].q1;
         @(negedge clk);
         chk($sformatf("row%0d_cmd_ready", k), 64'(cmd_ready), 64'(tbl[k].e_rdy));
         chk($sformatf("row%0d_dout_valid", k), 64'(dout_valid), 64'(tbl[k].e_valid));
         if (tbl[k].e_valid) begin
            chk($sformatf("row%0d_dout_bits", k), 64'(dout_bits), 64'(tbl[k].e_bits));
            chk($sformatf("row%0d_dout_last", k), 64'(dout_last), 64'(tbl[k].e_last));
         end
      end

      // Overflow: 256-sample capture into a 32-deep buffer with no reader
      dout_ready = 1'b0;
      trig_level = '0;
      issue_cmd(32'h0000_00FF);
      for (int k = 0; k < 256; k++) begin
         next_row();
         adc_valid_i0 = 1'b1;
         adc_data_i0  = 16'(k + 1);
         adc_data_q0  = 16'h0000;
      end
      repeat (3) next_row();
      @(negedge clk);
      chk("ovf_set",          64'(ovf),        64'd1);
      chk("ovf_drop_count",   64'(drop_count), 64'd224);
      chk("ovf_head_valid",   64'(dout_valid), 64'd1);
      chk("ovf_head_bits",    64'(dout_bits),  64'h0000_0001);
      chk("ovf_busy",         64'(busy),       64'd1);
      chk("ovf_cmd_ready",    64'(cmd_ready),  64'd1);

      // ovf_clr alone clears, ovf_clr together with a drop leaves ovf=1, count=1
      issue_cmd(32'h0000_0000);
      next_row();
      adc_valid_i0 = 1'b1;
      adc_data_i0  = 16'h1234;
      ovf_clr      = 1'b1;
      next_row();
      ovf_clr = 1'b1;
      @(negedge clk);
      chk("clr_ovf",        64'(ovf),        64'd0);
      chk("clr_drop_count", 64'(drop_count), 64'd0);
      next_row();
      @(negedge clk);
      chk("clr_vs_drop_ovf",   64'(ovf),        64'd1);
      chk("clr_vs_drop_count", 64'(drop_count), 64'd1);
      next_row();
      ovf_clr = 1'b1;
      next_row();
      @(negedge clk);
      chk("final_clr_ovf",   64'(ovf),        64'd0);
      chk("final_clr_count", 64'(drop_count), 64'd0);

      // Drain: the 32 oldest samples, none marked last
      for (int k = 0; k < 32; k++) begin
         next_row();
         dout_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("drain%0d_valid", k), 64'(dout_valid), 64'd1);
         chk($sformatf("drain%0d_bits", k),  64'(dout_bits),  64'(32'(k + 1)));
         chk($sformatf("drain%0d_last", k),  64'(dout_last),  64'd0);
      end
      next_row();
      @(negedge clk);
      chk("drain_empty", 64'(dout_valid), 64'd0);
      chk("drain_busy",  64'(busy),       64'd0);

      // Reset in the middle of a capture with five words buffered
      dout_ready = 1'b0;
      issue_cmd(32'h0000_0009);
      for (int k = 0; k < 5; k++) begin
         next_row();
         adc_valid_i0 = 1'b1;
         adc_data_i0  = 16'(16'h0100 + k);
         adc_data_q0  = 16'h0000;
      end
      repeat (2) next_row();
      @(negedge clk);
      chk("midcap_valid", 64'(dout_valid), 64'd1);
      chk("midcap_bits",  64'(dout_bits),  64'h0000_0100);
      chk("midcap_busy",  64'(busy),       64'd1);
      next_row();
      rst = 1'b1;
      next_row();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid",     64'(dout_valid), 64'd0);
      chk("rst_mid_cmd_ready", 64'(cmd_ready),  64'd1);
      chk("rst_mid_busy",      64'(busy),       64'd0);
      dout_ready = 1'b1;
      issue_cmd(32'h0000_0000);
      next_row();
      adc_valid_i0 = 1'b1;
      adc_data_i0  = 16'h0055;
      adc_data_q0  = 16'h0066;
      next_row();
      next_row();
      @(negedge clk);
      chk("post_rst_valid", 64'(dout_valid), 64'd1);
      chk("post_rst_bits",  64'(dout_bits),  64'h0066_0055);
      chk("post_rst_last",  64'(dout_last),  64'd1);
      next_row();
      @(negedge clk);
      chk("post_rst_empty", 64'(dout_valid), 64'd0);

      // Reserved mode is consumed with no output; next command one cycle later
      next_row();
      cmd_valid = 1'b1;
      cmd_bits  = 32'h0000_0300;
      @(negedge clk);
      chk("rsvd_ready", 64'(cmd_ready), 64'd1);
      next_row();
      cmd_valid = 1'b1;
      cmd_bits  = 32'h0000_0000;
      @(negedge clk);
      chk("rsvd_back_idle", 64'(cmd_ready),  64'd1);
      chk("rsvd_no_output", 64'(dout_valid), 64'd0);
      next_row();
      adc_valid_i0 = 1'b1;
      adc_data_i0  = 16'h0077;
      adc_data_q0  = 16'h0088;
      @(negedge clk);
      chk("second_cmd_taken", 64'(cmd_ready),  64'd0);
      chk("rsvd_no_output2",  64'(dout_valid), 64'd0);
      next_row();
      @(negedge clk);
      chk("second_lat_valid", 64'(dout_valid), 64'd0);
      next_row();
      @(negedge clk);
      chk("second_valid", 64'(dout_valid), 64'd1);
      chk("second_bits",  64'(dout_bits),  64'h0088_0077);
      chk("second_last",  64'(dout_last),  64'd1);
      next_row();
      @(negedge clk);
      chk("second_empty", 64'(dout_valid), 64'd0);
      chk("second_busy",  64'(busy),       64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
